updown_sweep_ctrl: RTL and testbench

Sequencer that drives an up/down count register through repeated triangle sweeps: 0 up to a programmable limit, then back down to 0. It optionally dwells at each end point. It sits beside the existing up/down counter datapath and replaces free-running up_down toggling with a start/abort/done handshake. Status outputs let a host wait for a fixed number of sweeps.

---
 rtl/updown_sweep_pkg.sv | 15 +
 rtl/sweep_counter_core.sv | 35 +++
 rtl/updown_sweep_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_sweep_pkg.sv
// Shared types for the up/down triangle-sweep sequencer.
package updown_sweep_pkg;

   typedef enum logic [2:0] {
      IDLE,
      UP,
      DWELL_TOP,
      DOWN,
      DWELL_BOT
   } sweep_state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/sweep_counter_core.sv
// Bounded up/down count register: clear has priority, then a single step
// in the requested direction that never wraps past 0 or all-ones.
module sweep_counter_core
   import updown_sweep_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_dir,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         if (i_dir == DIR_UP) begin
            if (r_count != '1) r_count <= r_count + WIDTH'(1);
         end else begin
            if (r_count != '0) r_count <= r_count - WIDTH'(1);
         end
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer: runs the count 0 -> limit -> 0 for a latched
// number of sweeps (or until abort), with optional dwell at both end points.
module updown_sweep_ctrl
   import updown_sweep_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int DWELL   = 2,
   parameter int SWEEP_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   limit,
   input  logic [SWEEP_W-1:0] num_sweeps,
   output logic [WIDTH-1:0]   count,
   output logic               up_down,
   output logic               busy,
   output logic               done,
   output logic [SWEEP_W-1:0] sweep_cnt
);

   localparam int                 DWELL_W    = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
   localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL);
   localparam bit                 HAS_DWELL  = (DWELL > 0);

   sweep_state_t       r_state;
   logic               r_up_down;
   logic               r_busy;
   logic               r_done;
   logic [SWEEP_W-1:0] r_sweep_cnt;
   logic [DWELL_W-1:0] r_dwell;
   logic [WIDTH-1:0]   r_limit;
   logic [SWEEP_W-1:0] r_num;

   sweep_state_t       w_state_nxt;
   logic               w_up_down_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic [SWEEP_W-1:0] w_sweep_nxt;
   logic [DWELL_W-1:0] w_dwell_nxt;
   logic [WIDTH-1:0]   w_limit_nxt;
   logic [SWEEP_W-1:0] w_num_nxt;
   logic               w_cnt_clr;
   logic               w_cnt_en;
   logic               w_cnt_dir;
   logic [SWEEP_W-1:0] w_sweep_inc;
   logic [WIDTH-1:0]   w_count;

   sweep_counter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_cnt_clr),
      .i_en    (w_cnt_en),
      .i_dir   (w_cnt_dir),
      .o_count (w_count)
   );

   // Saturating so continuous runs park at all-ones instead of wrapping.
   assign w_sweep_inc = (r_sweep_cnt == '1) ? r_sweep_cnt : r_sweep_cnt + SWEEP_W'(1);

   // NOTE: every signal driven here gets a default first, so no path infers a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_up_down_nxt = r_up_down;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_sweep_nxt   = r_sweep_cnt;
      w_dwell_nxt   = r_dwell;
      w_limit_nxt   = r_limit;
      w_num_nxt     = r_num;
      w_cnt_clr     = 1'b0;
      w_cnt_en      = 1'b0;
      w_cnt_dir     = DIR_UP;

      if (abort && (r_state != IDLE)) begin
         w_state_nxt   = IDLE;
         w_up_down_nxt = DIR_DOWN;
         w_busy_nxt    = 1'b0;
         w_cnt_clr     = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (start && !abort) begin
                  w_limit_nxt = limit;
                  w_num_nxt   = num_sweeps;
                  w_sweep_nxt = '0;
                  w_cnt_clr   = 1'b1;
                  if (limit == '0) begin
                     w_done_nxt = 1'b1;
                  end else begin
                     w_state_nxt   = UP;
                     w_up_down_nxt = DIR_UP;
                     w_busy_nxt    = 1'b1;
                  end
               end
            end
            UP: begin
               w_cnt_en  = 1'b1;
               w_cnt_dir = DIR_UP;
               if (w_count + WIDTH'(1) == r_limit) begin
                  if (HAS_DWELL) begin
                     w_state_nxt = DWELL_TOP;
                     w_dwell_nxt = DWELL_LOAD;
                  end else begin
                     w_state_nxt   = DOWN;
                     w_up_down_nxt = DIR_DOWN;
                  end
               end
            end
            DWELL_TOP: begin
               w_dwell_nxt = r_dwell - DWELL_W'(1);
               if (r_dwell == DWELL_W'(1)) begin
                  w_state_nxt   = DOWN;
                  w_up_down_nxt = DIR_DOWN;
               end
            end
            DOWN: begin
               w_cnt_en  = 1'b1;
               w_cnt_dir = DIR_DOWN;
               if (w_count == WIDTH'(1)) begin
                  w_sweep_nxt = w_sweep_inc;
                  if ((r_num != '0) && (w_sweep_inc == r_num)) begin
                     w_state_nxt = IDLE;
                     w_busy_nxt  = 1'b0;
                     w_done_nxt  = 1'b1;
                  end else if (HAS_DWELL) begin
                     w_state_nxt = DWELL_BOT;
                     w_dwell_nxt = DWELL_LOAD;
                  end else begin
                     w_state_nxt   = UP;
                     w_up_down_nxt = DIR_UP;
                  end
               end
            end
            DWELL_BOT: begin
               w_dwell_nxt = r_dwell - DWELL_W'(1);
               if (r_dwell == DWELL_W'(1)) begin
                  w_state_nxt   = UP;
                  w_up_down_nxt = DIR_UP;
               end
            end
            default: begin
               w_state_nxt   = IDLE;
               w_up_down_nxt = DIR_DOWN;
               w_busy_nxt    = 1'b0;
               w_cnt_clr     = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_up_down   <= DIR_DOWN;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_sweep_cnt <= '0;
         r_dwell     <= '0;
         r_limit     <= '0;
         r_num       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_up_down   <= w_up_down_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_sweep_cnt <= w_sweep_nxt;
         r_dwell     <= w_dwell_nxt;
         r_limit     <= w_limit_nxt;
         r_num       <= w_num_nxt;
      end
   end

   assign count     = w_count;
   assign up_down   = r_up_down;
   assign busy      = r_busy;
   assign done      = r_done;
   assign sweep_cnt = r_sweep_cnt;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench: two instances (no dwell, dwell of 2) checked against a
// per-cycle scoreboard of expected count/status samples.
module tb_updown_sweep_ctrl;

   logic       clk;
   logic       reset;

   logic       a_start, a_abort, a_up_down, a_busy, a_done;
   logic [3:0] a_limit, a_count;
   logic [7:0] a_num, a_sweep;

   logic       b_start, b_abort, b_up_down, b_busy, b_done;
   logic [3:0] b_limit, b_count;
   logic [7:0] b_num, b_sweep;

   int n_compared;
   int n_mismatched;

   typedef struct {
      int cnt;
      bit ud;
      bit ud_v;
      bit busy;
      bit done;
      int sweep;
   } exp_t;

   exp_t exp_q[$];

   updown_sweep_ctrl #(.WIDTH(4), .DWELL(0), .SWEEP_W(8)) dut_a (
      .clk        (clk),
      .reset      (reset),
      .start      (a_start),
      .abort      (a_abort),
      .limit      (a_limit),
      .num_sweeps (a_num),
      .count      (a_count),
      .up_down    (a_up_down),
      .busy       (a_busy),
      .done       (a_done),
      .sweep_cnt  (a_sweep)
   );

   updown_sweep_ctrl #(.WIDTH(4), .DWELL(2), .SWEEP_W(8)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .start      (b_start),
      .abort      (b_abort),
      .limit      (b_limit),
      .num_sweeps (b_num),
      .count      (b_count),
      .up_down    (b_up_down),
      .busy       (b_busy),
      .done       (b_done),
      .sweep_cnt  (b_sweep)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(int c, bit ud, bit udv, bit b, bit d, int s);
      exp_t e;
      e.cnt   = c;
      e.ud    = ud;
      e.ud_v  = udv;
      e.busy  = b;
      e.done  = d;
      e.sweep = s;
      return e;
   endfunction

   // Expected samples from the cycle after the start edge onward.
   task automatic push_model(input int lim, input int dw, input int nsw, input bit finite);
      exp_q.push_back(mk(0, 1'b1, 1'b1, 1'b1, 1'b0, 0));
      for (int s = 1; s <= nsw; s++) begin
         for (int c = 1; c < lim; c++) exp_q.push_back(mk(c, 1'b1, 1'b1, 1'b1, 1'b0, s - 1));
         for (int k = 0; k <= dw; k++) exp_q.push_back(mk(lim, 1'b1, (k < dw), 1'b1, 1'b0, s - 1));
         for (int c = lim - 1; c >= 1; c--) exp_q.push_back(mk(c, 1'b0, 1'b1, 1'b1, 1'b0, s - 1));
         if (finite && (s == nsw)) begin
            exp_q.push_back(mk(0, 1'b0, 1'b1, 1'b0, 1'b1, s));
            exp_q.push_back(mk(0, 1'b0, 1'b1, 1'b0, 1'b0, s));
         end else begin
            for (int k = 0; k <= dw; k++) exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b1, 1'b0, s));
         end
      end
   endtask

   // Pops and compares n samples, one per falling edge; optionally pokes
   // start/limit on instance A at sample poke_at.
   task automatic drain(input bit sel_b, input string tag, input int n, input int poke_at);
      exp_t        e;
      logic [31:0] o_cnt, o_sweep;
      logic        o_ud, o_busy, o_done;
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL %s: scoreboard empty at sample %0d", tag, i);
            break;
         end
         e = exp_q.pop_front();
         if (sel_b) begin
            o_cnt = {28'd0, b_count}; o_sweep = {24'd0, b_sweep};
            o_ud = b_up_down; o_busy = b_busy; o_done = b_done;
         end else begin
            o_cnt = {28'd0, a_count}; o_sweep = {24'd0, a_sweep};
            o_ud = a_up_down; o_busy = a_busy; o_done = a_done;
         end
         n_compared++;
         if (o_cnt !== e.cnt) begin
            n_mismatched++;
            $display("FAIL %s count[%0d]: got %0d expected %0d", tag, i, o_cnt, e.cnt);
         end
         n_compared++;
         if (o_busy !== e.busy) begin
            n_mismatched++;
            $display("FAIL %s busy[%0d]: got %b expected %b", tag, i, o_busy, e.busy);
         end
         n_compared++;
         if (o_done !== e.done) begin
            n_mismatched++;
            $display("FAIL %s done[%0d]: got %b expected %b", tag, i, o_done, e.done);
         end
         n_compared++;
         if (o_sweep !== e.sweep) begin
            n_mismatched++;
            $display("FAIL %s sweep_cnt[%0d]: got %0d expected %0d", tag, i, o_sweep, e.sweep);
         end
         if (e.ud_v) begin
            n_compared++;
            if (o_ud !== e.ud) begin
               n_mismatched++;
               $display("FAIL %s up_down[%0d]: got %b expected %b", tag, i, o_ud, e.ud);
            end
         end
         if (poke_at >= 0 && i == poke_at) begin
            a_start = 1'b1;
            a_limit = 4'd7;
         end else if (poke_at >= 0 && i == poke_at + 1) begin
            a_start = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic start_a(input logic [3:0] lim, input logic [7:0] num);
      a_limit = lim;
      a_num   = num;
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
   endtask

   task automatic start_b(input logic [3:0] lim, input logic [7:0] num);
      b_limit = lim;
      b_num   = num;
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_compared++;
      if ({a_count, a_up_down, a_busy, a_done, a_sweep} !== 15'd0) begin
         n_mismatched++;
         $display("FAIL reset_a: got %h expected 0", {a_count, a_up_down, a_busy, a_done, a_sweep});
      end
      n_compared++;
      if ({b_count, b_up_down, b_busy, b_done, b_sweep} !== 15'd0) begin
         n_mismatched++;
         $display("FAIL reset_b: got %h expected 0", {b_count, b_up_down, b_busy, b_done, b_sweep});
      end
      reset = 1'b0;
      @(negedge clk);
      n_compared++;
      if ({a_count, a_busy, a_done} !== 6'd0) begin
         n_mismatched++;
         $display("FAIL reset_release_a: got %h expected 0", {a_count, a_busy, a_done});
      end
   endtask

   task automatic test_sweep_nodwell();
      push_model(3, 0, 2, 1'b1);
      start_a(4'd3, 8'd2);
      drain(1'b0, "nodwell_L3_N2", 14, -1);
   endtask

   task automatic test_dwell();
      push_model(2, 2, 1, 1'b1);
      start_b(4'd2, 8'd1);
      drain(1'b1, "dwell_L2_N1", 8, -1);
      push_model(2, 2, 2, 1'b1);
      start_b(4'd2, 8'd2);
      drain(1'b1, "dwell_L2_N2", 16, -1);
   endtask

   task automatic test_zero_limit();
      start_a(4'd0, 8'd1);
      n_compared++;
      if ({a_done, a_busy, a_count, a_sweep} !== {1'b1, 1'b0, 4'd0, 8'd0}) begin
         n_mismatched++;
         $display("FAIL zero_limit_pulse: got done=%b busy=%b count=%0d sweep=%0d expected 1 0 0 0",
                  a_done, a_busy, a_count, a_sweep);
      end
      @(negedge clk);
      n_compared++;
      if ({a_done, a_busy, a_count} !== 6'd0) begin
         n_mismatched++;
         $display("FAIL zero_limit_after: got done=%b busy=%b count=%0d expected 0 0 0",
                  a_done, a_busy, a_count);
      end
      push_model(15, 0, 1, 1'b1);
      start_a(4'd15, 8'd1);
      drain(1'b0, "max_limit", 32, -1);
   endtask

   task automatic test_continuous_abort();
      push_model(4, 0, 3, 1'b0);
      start_a(4'd4, 8'd0);
      drain(1'b0, "continuous", 21, -1);
      exp_q.delete();
      a_abort = 1'b1;
      @(negedge clk);
      a_abort = 1'b0;
      n_compared++;
      if ({a_count, a_busy, a_up_down, a_done, a_sweep} !== {4'd0, 1'b0, 1'b0, 1'b0, 8'd2}) begin
         n_mismatched++;
         $display("FAIL abort: got count=%0d busy=%b up_down=%b done=%b sweep=%0d expected 0 0 0 0 2",
                  a_count, a_busy, a_up_down, a_done, a_sweep);
      end
      @(negedge clk);
      n_compared++;
      if ({a_count, a_busy, a_done} !== 6'd0) begin
         n_mismatched++;
         $display("FAIL abort_after: got count=%0d busy=%b done=%b expected 0 0 0",
                  a_count, a_busy, a_done);
      end
   endtask

   task automatic test_busy_ignore();
      push_model(3, 0, 1, 1'b1);
      start_a(4'd3, 8'd1);
      drain(1'b0, "busy_ignore", 8, 2);
      a_limit = 4'd3;
   endtask

   task automatic test_start_abort_idle();
      a_limit = 4'd3;
      a_num   = 8'd1;
      a_start = 1'b1;
      a_abort = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      a_abort = 1'b0;
      n_compared++;
      if ({a_busy, a_count, a_up_down, a_done, a_sweep} !== {1'b0, 4'd0, 1'b0, 1'b0, 8'd1}) begin
         n_mismatched++;
         $display("FAIL start_abort_idle: got busy=%b count=%0d up_down=%b done=%b sweep=%0d expected 0 0 0 0 1",
                  a_busy, a_count, a_up_down, a_done, a_sweep);
      end
      @(negedge clk);
      @(negedge clk);
      n_compared++;
      if ({a_busy, a_count} !== 5'd0) begin
         n_mismatched++;
         $display("FAIL start_abort_idle_later: got busy=%b count=%0d expected 0 0", a_busy, a_count);
      end
   endtask

   task automatic test_reset_mid_sweep();
      start_a(4'd5, 8'd0);
      @(negedge clk);
      @(negedge clk);
      n_compared++;
      if ({a_count, a_up_down, a_busy} !== {4'd2, 1'b1, 1'b1}) begin
         n_mismatched++;
         $display("FAIL pre_reset: got count=%0d up_down=%b busy=%b expected 2 1 1",
                  a_count, a_up_down, a_busy);
      end
      #2;
      reset = 1'b1;
      #1;
      n_compared++;
      if ({a_count, a_up_down, a_busy, a_sweep} !== 14'd0) begin
         n_mismatched++;
         $display("FAIL async_reset: got count=%0d up_down=%b busy=%b sweep=%0d expected 0 0 0 0",
                  a_count, a_up_down, a_busy, a_sweep);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      n_compared++;
      if ({a_count, a_up_down, a_busy, a_done} !== 7'd0) begin
         n_mismatched++;
         $display("FAIL post_reset_idle: got count=%0d up_down=%b busy=%b done=%b expected 0 0 0 0",
                  a_count, a_up_down, a_busy, a_done);
      end
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      reset   = 1'b1;
      a_start = 1'b0; a_abort = 1'b0; a_limit = 4'd0; a_num = 8'd0;
      b_start = 1'b0; b_abort = 1'b0; b_limit = 4'd0; b_num = 8'd0;

      test_reset();
      test_sweep_nodwell();
      test_dwell();
      test_zero_limit();
      test_continuous_abort();
      test_busy_ignore();
      test_start_abort_idle();
      test_reset_mid_sweep();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
